// File: rtl/i2s_rx.sv
// i2s_rx: I2S capture path. Oversamples the codec's sclk/lrclk/dout in the
// system clock domain, deserializes MSB-first stereo words and queues
// complete {left, right} frames in a small FIFO.
//
// Ports:
//   clk, reset   system clock, asynchronous active-high reset
//   en           capture enable (low holds the deserializer idle, FIFO kept)
//   flush        synchronous clear of FIFO contents and overflow
//   sclk, lrclk, dout   codec bit clock, word clock (0 = left), serial data
//   rd_req       pop request
//   rd_data      popped frame {left, right}, holds between pops
//   rd_valid     one-cycle strobe marking rd_data as a freshly popped frame
//   empty, full, level  FIFO occupancy
//   overflow     sticky, a completed frame was dropped because the FIFO was full
//
// Read handshake: rd_req sampled high on a clock edge while the FIFO holds at
// least one frame pops the oldest frame; rd_valid is high for exactly the next
// cycle with that frame on rd_data. rd_req against an empty FIFO is ignored
// (no rd_valid). There is no back-pressure: requests may be issued every cycle.
module i2s_rx #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      flush,
    input  logic                      sclk,
    input  logic                      lrclk,
    input  logic                      dout,
    input  logic                      rd_req,
    output logic [2*DATA_WIDTH-1:0]   rd_data,
    output logic                      rd_valid,
    output logic                      empty,
    output logic                      full,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] DW_C    = CW'(DATA_WIDTH);
    localparam logic [CW-1:0] DW_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // Synchronizers and sclk rising-edge detector. lr_s/dout_s are
    // registered alongside bit_tick so all three describe the same sclk edge.
    // ------------------------------------------------------------------
    logic [1:0] sclk_sync;
    logic [1:0] lr_sync;
    logic [1:0] dout_sync;
    logic       sclk_d;
    logic       bit_tick;
    logic       lr_s;
    logic       dout_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= 2'b00;
            lr_sync   <= 2'b00;
            dout_sync <= 2'b00;
            sclk_d    <= 1'b0;
            bit_tick  <= 1'b0;
            lr_s      <= 1'b0;
            dout_s    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], sclk};
            lr_sync   <= {lr_sync[0], lrclk};
            dout_sync <= {dout_sync[0], dout};
            sclk_d    <= sclk_sync[1];
            bit_tick  <= sclk_sync[1] & ~sclk_d;
            lr_s      <= lr_sync[1];
            dout_s    <= dout_sync[1];
        end
    end

    // ------------------------------------------------------------------
    // Slot framing FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic                  lr_prev;
    logic                  lr_change;
    logic [CW-1:0]         bitcnt;
    logic                  chan;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] left_hold;
    logic                  left_ok;

    logic                  slot_start;
    logic                  take_bit;
    logic                  word_done;
    logic                  push;
    logic [DATA_WIDTH:0]   shift_wide;
    logic [DATA_WIDTH-1:0] shift_next;
    logic [2*DATA_WIDTH-1:0] push_frame;

    assign lr_change = lr_s ^ lr_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (en) state_next = ST_SYNC;
            end
            ST_SYNC: begin
                if (!en)                        state_next = ST_IDLE;
                else if (bit_tick && lr_change) state_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (!en) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A slot boundary is an lrclk change seen on a bit tick. The bit sampled
    // on that tick still belongs to the previous slot (I2S one-bit delay), so
    // it is never shifted in.
    always_comb begin
        slot_start = en && (state != ST_IDLE) && bit_tick && lr_change;
        take_bit   = en && (state == ST_CAPTURE) && bit_tick && !lr_change
                     && (bitcnt < DW_C);
        word_done  = take_bit && (bitcnt == DW_LAST);
        shift_wide = {shreg, dout_s};
        shift_next = shift_wide[DATA_WIDTH-1:0];
        push       = word_done && chan && left_ok;
        push_frame = {left_hold, shift_next};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lr_prev   <= 1'b0;
            bitcnt    <= '0;
            chan      <= 1'b0;
            shreg     <= '0;
            left_hold <= '0;
            left_ok   <= 1'b0;
        end else begin
            // lr_prev tracks lrclk even while idle so enabling mid-slot
            // does not see a phantom boundary.
            if (bit_tick) lr_prev <= lr_s;

            if (!en || state == ST_IDLE) begin
                bitcnt  <= '0;
                left_ok <= 1'b0;
            end else if (slot_start) begin
                bitcnt <= '0;
                chan   <= lr_s;
                // A slot that ended short breaks the current pair.
                if (bitcnt < DW_C) left_ok <= 1'b0;
            end else if (take_bit) begin
                shreg  <= shift_next;
                bitcnt <= bitcnt + CW'(1);
                if (word_done) begin
                    if (!chan) begin
                        left_hold <= shift_next;
                        left_ok   <= 1'b1;
                    end else begin
                        // Right word consumed: pushed if paired, else dropped.
                        left_ok <= 1'b0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FIFO
    // ------------------------------------------------------------------
    logic [2*DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [AW:0]             count;
    logic                    do_pop;
    logic                    do_push;

    // A pop frees the slot the same-cycle push lands in, so push at full
    // still succeeds when paired with a pop.
    always_comb begin
        do_pop  = rd_req && (count != '0);
        do_push = push && ((count != DEPTH_C) || do_pop);
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_frame;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= do_pop;
            if (do_pop) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + AW'(1);
            end
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (push && !do_push) overflow <= 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign level = count;
    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);

endmodule

// File: tb/tb_i2s_rx.sv
`timescale 1ns/1ps
module tb_i2s_rx;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int FW    = 2 * DW;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          flush;
    logic          sclk;
    logic          lrclk;
    logic          dout;
    logic          rd_req;
    logic [FW-1:0] rd_data;
    logic          rd_valid;
    logic          empty;
    logic          full;
    logic [3:0]    level;
    logic          overflow;

    always #5 clk = ~clk;

    i2s_rx #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .flush    (flush),
        .sclk     (sclk),
        .lrclk    (lrclk),
        .dout     (dout),
        .rd_req   (rd_req),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .empty    (empty),
        .full     (full),
        .level    (level),
        .overflow (overflow)
    );

    // ------------------------------------------------------------------
    // Scoreboard and model state
    // ------------------------------------------------------------------
    int            total = 0;
    int            bad   = 0;
    logic [FW-1:0] exp_q[$];
    logic          exp_ovf  = 1'b0;
    logic [FW-1:0] exp_last = '0;
    logic          cmp_rv;

    // Slot-level capture model: a slot counts only if en was high when it
    // began; the first counted slot must start on an lrclk change.
    bit            m_synced    = 1'b0;
    bit            m_have_left = 1'b0;
    bit            m_last_lr   = 1'b0;
    logic [DW-1:0] m_left      = '0;
    bit            slot_broken = 1'b0;
    bit            quiet       = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_push(input logic [FW-1:0] frame);
        if (exp_q.size() < DEPTH) exp_q.push_back(frame);
        else                      exp_ovf = 1'b1;
    endtask

    task automatic model_slot(input bit lr, input bit en_start, input logic [DW-1:0] word, input int nb);
        if (!en_start) begin
            m_synced    = 1'b0;
            m_have_left = 1'b0;
        end else if (!slot_broken) begin
            if (!m_synced && lr != m_last_lr) m_synced = 1'b1;
            if (m_synced) begin
                if (nb < DW) begin
                    m_have_left = 1'b0;
                end else if (!lr) begin
                    m_left      = word;
                    m_have_left = 1'b1;
                end else begin
                    if (m_have_left) model_push({m_left, word});
                    m_have_left = 1'b0;
                end
            end
        end
        m_last_lr = lr;
    endtask

    task automatic model_disable();
        m_synced    = 1'b0;
        m_have_left = 1'b0;
    endtask

    task automatic model_reset();
        m_synced    = 1'b0;
        m_have_left = 1'b0;
        slot_broken = 1'b1;
        exp_q.delete();
        exp_ovf  = 1'b0;
        exp_last = '0;
    endtask

    // Compare process: FIFO side modelled cycle by cycle with the queue;
    // occupancy only compared when no serial transfer is in flight.
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            cmp_rv = 1'b0;
            if (flush) begin
                exp_q.delete();
                exp_ovf = 1'b0;
            end else if (rd_req && exp_q.size() > 0) begin
                cmp_rv   = 1'b1;
                exp_last = exp_q.pop_front();
            end
            check("rd_valid", rd_valid, cmp_rv);
            check("rd_data", rd_data, exp_last);
            if (quiet) begin
                check("level", level, exp_q.size());
                check("empty", empty, exp_q.size() == 0);
                check("full", full, exp_q.size() == DEPTH);
                check("overflow", overflow, exp_ovf);
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks (all start and end on a falling clk edge)
    // ------------------------------------------------------------------
    // One I2S slot: position 0 carries the previous slot's LSB, positions
    // 1..DW carry the word MSB first, the rest is random padding.
    task automatic send_slot(input bit lr, input logic [DW-1:0] word, input int slotlen, input bit pop_at_push);
        bit en_start;
        int nb;
        quiet       = 1'b0;
        slot_broken = 1'b0;
        en_start    = en;
        for (int p = 0; p < slotlen; p++) begin
            sclk  = 1'b0;
            lrclk = lr;
            if (p >= 1 && p <= DW) dout = word[DW-p];
            else                   dout = 1'($urandom_range(0, 1));
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            if (pop_at_push && lr && p == DW) begin
                // bit_tick is 3 cycles after sclk rises; the push commits on
                // the edge that ends that cycle.
                repeat (3) @(negedge clk);
                rd_req = 1'b1;
                @(negedge clk);
                rd_req = 1'b0;
            end else begin
                repeat (4) @(negedge clk);
            end
        end
        nb = (slotlen - 1 < DW) ? slotlen - 1 : DW;
        model_slot(lr, en_start, word, nb);
    endtask

    task automatic settle();
        repeat (6) @(negedge clk);
        quiet = 1'b1;
    endtask

    task automatic send_pair(input logic [DW-1:0] l, input logic [DW-1:0] r, input int slotlen);
        send_slot(1'b0, l, slotlen, 1'b0);
        send_slot(1'b1, r, slotlen, 1'b0);
        settle();
    endtask

    task automatic pop_expect(input string name, input logic [FW-1:0] val);
        rd_req = 1'b1;
        @(posedge clk);
        #2;
        check({name, "_valid"}, rd_valid, 1'b1);
        check(name, rd_data, val);
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic pop_none(input string name);
        rd_req = 1'b1;
        @(posedge clk);
        #2;
        check(name, rd_valid, 1'b0);
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        reset  = 1'b1;
        en     = 1'b0;
        flush  = 1'b0;
        sclk   = 1'b0;
        lrclk  = 1'b0;
        dout   = 1'b0;
        rd_req = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_level", level, 0);
        check("rst_overflow", overflow, 0);
        reset = 1'b0;
        en    = 1'b1;
        @(negedge clk);
        quiet = 1'b1;

        // Basic capture, 32-bit slots; leading right slot has no partner.
        send_slot(1'b1, 16'h5A5A, 32, 1'b0);
        send_slot(1'b0, 16'hA5C3, 32, 1'b0);
        send_slot(1'b1, 16'h1234, 32, 1'b0);
        settle();
        check("basic_level", level, 1);
        check("basic_empty", empty, 0);
        pop_expect("basic_data", 32'hA5C31234);
        check("basic_level_after", level, 0);
        check("basic_empty_after", empty, 1);

        // Enable in the middle of a right slot.
        en = 1'b0;
        model_disable();
        send_slot(1'b0, 16'h1111, 20, 1'b0);
        fork
            send_slot(1'b1, 16'h2222, 20, 1'b0);
            begin
                repeat (12) @(negedge clk);
                en = 1'b1;
            end
        join
        send_pair(16'h3333, 16'h4444, 20);
        check("mid_level", level, 1);
        pop_expect("mid_data", 32'h33334444);

        // Short left slot, then full left with short right, then a good pair.
        send_slot(1'b0, 16'hDEAD, 11, 1'b0);
        send_slot(1'b1, 16'hBEEF, 20, 1'b0);
        send_slot(1'b0, 16'h7777, 20, 1'b0);
        send_slot(1'b1, 16'h8888, 11, 1'b0);
        send_pair(16'hCAFE, 16'hF00D, 20);
        check("short_level", level, 1);
        pop_expect("short_data", 32'hCAFEF00D);

        // Overflow: nine frames into an eight-deep FIFO.
        for (int i = 0; i < 9; i++) send_pair(16'h1100 + 16'(i), 16'h2200 + 16'(i), 17);
        check("ovf_full", full, 1);
        check("ovf_level", level, 8);
        check("ovf_flag", overflow, 1);
        for (int i = 0; i < 8; i++) pop_expect("ovf_data", {16'h1100 + 16'(i), 16'h2200 + 16'(i)});
        pop_none("ovf_ninth_absent");
        check("ovf_sticky", overflow, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_level", level, 0);
        check("flush_overflow", overflow, 0);

        // Pop lands on the same edge as a push into a full FIFO.
        for (int i = 0; i < 8; i++) send_pair(16'h3300 + 16'(i), 16'h4400 + 16'(i), 17);
        check("simul_full_before", full, 1);
        send_slot(1'b0, 16'h55AA, 17, 1'b0);
        send_slot(1'b1, 16'hAA55, 17, 1'b1);
        settle();
        check("simul_level", level, 8);
        check("simul_overflow", overflow, 0);
        for (int i = 1; i < 8; i++) pop_expect("simul_data", {16'h3300 + 16'(i), 16'h4400 + 16'(i)});
        pop_expect("simul_last", 32'h55AAAA55);

        // Asynchronous reset in the middle of a right slot.
        send_pair(16'h6161, 16'h6262, 20);
        send_slot(1'b0, 16'h7171, 20, 1'b0);
        fork
            send_slot(1'b1, 16'h7272, 20, 1'b0);
            begin
                repeat (44) @(negedge clk);
                reset = 1'b1;
                model_reset();
                #1;
                check("arst_rd_data", rd_data, 0);
                check("arst_rd_valid", rd_valid, 0);
                check("arst_empty", empty, 1);
                check("arst_full", full, 0);
                check("arst_level", level, 0);
                check("arst_overflow", overflow, 0);
                repeat (2) @(negedge clk);
                reset = 1'b0;
            end
        join
        send_pair(16'h8181, 16'h8282, 20);
        check("arst_resume_level", level, 1);
        pop_expect("arst_resume_data", 32'h81818282);
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
